screen_state_sequencer: RTL
===========================

# screen_state_sequencer

Sequences the menu and countdown screens of the VGA display. It turns player button presses and per-frame ticks into the 3-bit screen-select code that the image display block consumes. Display updates are applied only at frame boundaries, so a screen change never tears mid-frame. The block sits between the input-conditioning logic and the image display, and starts the game after the 3-2-1 countdown.

## Interface
- FRAMES_PER_STEP, 60, frames each countdown digit stays on screen; legal range 2..255.
- clk  input  1  25 MHz pixel clock.
- rst  input  1  asynchronous, active-high reset.
- btn_up  input  1  level, asynchronous to clk; selects the P1 menu option.
- btn_down  input  1  level, asynchronous to clk; selects the P2 menu option.
- btn_select  input  1  level, asynchronous to clk; confirms the highlighted option.
- frame_start  input  1  one-cycle pulse per video frame, synchronous to clk.
- abort  input  1  synchronous one-cycle pulse from game logic; returns to the menu.
- display_state  output  3  screen code for the image display; reset value 3'b000.
- mode  output  1  0 = P1 option chosen, 1 = P2 option chosen; reset value 0.
- game_start  output  1  one-cycle pulse when play begins; reset value 0.

## Operation
- Each button passes through a 2-flop synchronizer and a third flop. A rising-edge pulse is formed as sync2 & ~sync3. Only rising edges act; holding a button repeats nothing.
- Internal FSM state_int uses the display encodings:
  - MENU_P1 = 000
  - MENU_P2 = 001
  - CD3 = 011
  - CD2 = 100
  - CD1 = 101
  - PLAY = 110
  - Code 010 and code 111 are never produced.
- MENU_P1: a down edge moves to MENU_P2. An up edge leaves the state unchanged.
- MENU_P2: an up edge moves to MENU_P1. A down edge leaves the state unchanged.
- Menu, simultaneous up and down edges: no change.
- Menu, select edge:
  - Latches mode (0 in MENU_P1, 1 in MENU_P2).
  - Clears frame_cnt and goes to CD3.
  - Select has priority over up/down edges arriving in the same cycle.
- CD3, CD2, CD1: frame_cnt (8 bits) increments on each frame_start.
  - When frame_start arrives with frame_cnt == FRAMES_PER_STEP-1, frame_cnt clears and the FSM advances CD3→CD2→CD1→PLAY.
  - Button edges are ignored in these states.
- Entering PLAY from CD1: game_start is high for exactly that one cycle. PLAY holds until abort; buttons are ignored.
- abort in any state:
  - state_int goes to MENU_P1 and frame_cnt clears; mode is kept.
  - abort overrides every other event in the same cycle.
  - abort during CD1's final frame suppresses game_start.
- display_state loads state_int on every cycle with frame_start = 1 and holds otherwise.
- If frame_start coincides with a state_int transition, display_state takes the pre-transition value. The new value appears on the next frame_start.
- Reset asserted at any time:
  - All flops clear immediately (state_int, display_state, mode, frame_cnt, synchronizers).
  - game_start drops to 0.
  - Pending edges are lost.

## Timing
- Button to state_int latency:
  - Input first sampled high at edge k; sync2 is high after k+1.
  - The edge pulse is valid during cycle k+1..k+2; state_int changes at edge k+2.
  - A button must be held at least 3 cycles to register reliably.
- state_int to display_state latency: the first frame_start after the change; up to one frame (420000 cycles at 640x480@60).
- Countdown timing: each digit lasts exactly FRAMES_PER_STEP frame_start pulses of state_int.
  - The CD3→CD2 transition occurs on the FRAMES_PER_STEP-th frame_start after entering CD3.
  - The entering frame_start is counted only if it arrives after the entry cycle.
- Total countdown: 3×FRAMES_PER_STEP frame_start pulses from CD3 entry to the game_start cycle.
- game_start: registered output, high exactly 1 cycle per play entry.
- frame_cnt never exceeds FRAMES_PER_STEP-1; no wrap-around beyond 255.

## Test plan
Use FRAMES_PER_STEP = 4 and frame_start every 20 cycles.
- Reset/idle:
  - Assert rst mid-cycle → display_state=000, mode=0, game_start=0 immediately.
  - Release with no stimulus for 10 frames → outputs unchanged.
- Menu navigation:
  - btn_down held 5 cycles → state_int=001 at edge k+2.
  - display_state=001 at the next frame_start.
  - Second down press → stays 001. btn_up press → display 000 one frame later.
- Full sequence:
  - In MENU_P2, press select → mode=1.
  - display_state then walks 011, 100, 101, 110, each held 4 frames.
  - game_start pulses once, 12 frame_starts after CD3 entry.
- Priority:
  - up+down edges in the same cycle → no change.
  - select+down in MENU_P1 → mode=0, state CD3.
  - Buttons pressed during CD2 → ignored; countdown timing unchanged.
- Abort:
  - abort pulse in CD2 → state_int=000 next cycle, frame_cnt=0, mode kept.
  - abort coinciding with CD1's 4th frame_start → no game_start, display goes to 000.
- Reset mid-countdown:
  - rst asserted in CD3 with frame_cnt=2 → all outputs reset asynchronously.
  - After release, a select press restarts the countdown with the full 4 frames for CD3.

Source files
------------

// File: rtl/screen_state_sequencer.sv
// Menu / 3-2-1 countdown sequencer for the VGA screen selector.
// Screen changes reach display_state only on frame_start, so the picture never tears mid-frame.
module screen_state_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_select,
    input  logic       frame_start,
    input  logic       abort,
    output logic [2:0] display_state,
    output logic       mode,
    output logic       game_start
);
    // state   | meaning
    // MENU_P1 | menu, P1 option highlighted
    // MENU_P2 | menu, P2 option highlighted
    // CD3     | countdown digit 3
    // CD2     | countdown digit 2
    // CD1     | countdown digit 1
    // PLAY    | game running until abort
    typedef enum logic [2:0] {
        MENU_P1 = 3'b000,
        MENU_P2 = 3'b001,
        CD3     = 3'b011,
        CD2     = 3'b100,
        CD1     = 3'b101,
        PLAY    = 3'b110
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAMES_PER_STEP - 1);

    logic [2:0] sync1_q, sync2_q, sync3_q;
    logic [2:0] btn_edge;
    logic       up_edge, down_edge, sel_edge;

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       mode_q, mode_d;
    logic       game_start_q, game_start_d;
    logic [2:0] disp_q;

    // Bit order: {select, down, up}; third flop gives the rising-edge reference.
    assign btn_edge  = sync2_q & ~sync3_q;
    assign up_edge   = btn_edge[0];
    assign down_edge = btn_edge[1];
    assign sel_edge  = btn_edge[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            sync3_q      <= 3'b000;
            state_q      <= MENU_P1;
            frame_cnt_q  <= 8'd0;
            mode_q       <= 1'b0;
            game_start_q <= 1'b0;
            disp_q       <= 3'b000;
        end else begin
            sync1_q      <= {btn_select, btn_down, btn_up};
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            mode_q       <= mode_d;
            game_start_q <= game_start_d;
            if (frame_start) begin
                disp_q <= state_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        mode_d       = mode_q;
        game_start_d = 1'b0;
        if (abort) begin
            state_d     = MENU_P1;
            frame_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                MENU_P1: begin
                    if (sel_edge) begin
                        mode_d      = 1'b0;
                        frame_cnt_d = 8'd0;
                        state_d     = CD3;
                    end else if (down_edge && !up_edge) begin
                        state_d = MENU_P2;
                    end
                end
                MENU_P2: begin
                    if (sel_edge) begin
                        mode_d      = 1'b1;
                        frame_cnt_d = 8'd0;
                        state_d     = CD3;
                    end else if (up_edge && !down_edge) begin
                        state_d = MENU_P1;
                    end
                end
                CD3, CD2, CD1: begin
                    if (frame_start) begin
                        if (frame_cnt_q == LAST_CNT) begin
                            frame_cnt_d = 8'd0;
                            if (state_q == CD3) begin
                                state_d = CD2;
                            end else if (state_q == CD2) begin
                                state_d = CD1;
                            end else begin
                                state_d      = PLAY;
                                game_start_d = 1'b1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                PLAY: state_d = PLAY;
                default: begin
                    state_d     = MENU_P1;
                    frame_cnt_d = 8'd0;
                end
            endcase
        end
    end

    assign display_state = disp_q;
    assign mode          = mode_q;
    assign game_start    = game_start_q;

endmodule
